scratch_mem_arbiter: RTL and testbench

- Shares the single scratch-memory write port and read port 0 between up to `NUM_REQ` requesters: histogram, CDF and divider engines, plus a spare slot.
- Uses round-robin arbitration with locked bursts.
- Checks every address against `scratch_mem_depth` and releases a stalled owner with a watchdog.
- Sits between the equalizer core engines and the scratch memory, in place of the phase-exclusive muxing.

---
 rtl/hist_eq_pkg.sv | 18 +
 rtl/scratch_mem_arbiter_if.sv | 30 +++
 rtl/rr_pick.sv | 34 +++
 rtl/scratch_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_scratch_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram-equalizer scratch path.
// Used by the scratch-memory arbiter and its requester interface.
package hist_eq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 128;
    localparam int DEPTH_W    = 17;

    localparam int REQ_HIST = 0;
    localparam int REQ_CDF  = 1;
    localparam int REQ_DIV  = 2;

endpackage

// File: rtl/scratch_mem_arbiter_if.sv
// Requester-side bus of the scratch-memory arbiter.
// The requesters drive the master side; the arbiter takes the slave side.
interface scratch_mem_arbiter_if
    import hist_eq_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_we, req_last, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_last, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first set request bit at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [1:0]   idx,
    output logic         found
);

    logic [3:0] req4;

    assign req4 = 4'(req);

    // Scan from ptr upward, keeping the first hit.
    always_comb begin
        logic [2:0] s;
        idx   = 2'd0;
        found = 1'b0;
        s     = 3'd0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, ptr} + 3'(k);
            if (s >= 3'(N)) begin
                s = s - 3'(N);
            end
            if (!found && req4[s[1:0]]) begin
                idx   = s[1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scratch_mem_arbiter.sv
// Shares the scratch write port and read port 0 between the engines.
// Round-robin grants, locked bursts, range check and idle watchdog.
module scratch_mem_arbiter
    import hist_eq_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    scratch_mem_arbiter_if.slave req_if,
    input  logic [DEPTH_W-1:0]   scratch_mem_depth,
    output logic                 scratch_mem_WE,
    output logic [ADDR_W-1:0]    scratch_mem_waddr,
    output logic [DATA_W-1:0]    scratch_mem_wdata,
    output logic [ADDR_W-1:0]    scratch_mem_raddr0,
    input  logic [DATA_W-1:0]    scratch_mem_rdata0,
    output logic [1:0]           owner,
    output logic                 overflow_fault,
    output logic                 timeout_fault
);

    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam int IC_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_nx;
    logic [1:0]        owner_nx;
    logic [1:0]        rr_ptr;
    logic [1:0]        rr_ptr_nx;
    logic [BC_W-1:0]   beat_cnt;
    logic [BC_W-1:0]   beat_nx;
    logic [IC_W-1:0]   idle_cnt;
    logic [IC_W-1:0]   idle_nx;
    logic              tof_nx;

    logic [1:0]        pick_idx;
    logic              pick_found;

    logic [3:0]        v4;
    logic [3:0]        we4;
    logic [3:0]        last4;
    logic [3:0]        rdy4;
    logic              sel_valid;
    logic              sel_we;
    logic              sel_last;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              acc;
    logic              flt;

    logic              rd_v1;
    logic [1:0]        rd_own1;
    logic              rd_flt1;
    logic [3:0]        rsp_oh;
    logic              rsp_flt2;

    rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .req  (req_if.req_valid),
        .ptr  (rr_ptr),
        .idx  (pick_idx),
        .found(pick_found)
    );

    assign v4        = 4'(req_if.req_valid);
    assign we4       = 4'(req_if.req_we);
    assign last4     = 4'(req_if.req_last);
    assign sel_valid = v4[owner];
    assign sel_we    = we4[owner];
    assign sel_last  = last4[owner];
    assign sel_addr  = req_if.req_addr[owner*ADDR_W +: ADDR_W];
    assign sel_wdata = req_if.req_wdata[owner*DATA_W +: DATA_W];

    assign acc = (state == BURST) && sel_valid;
    assign flt = DEPTH_W'(sel_addr) >= scratch_mem_depth;

    // Only the current owner sees ready, and only while bursting.
    always_comb begin
        rdy4        = 4'b0000;
        rdy4[owner] = (state == BURST);
    end

    assign req_if.req_ready = rdy4[NUM_REQ-1:0];
    assign req_if.rsp_valid = rsp_oh[NUM_REQ-1:0];
    assign req_if.rsp_rdata = (rsp_oh != 4'b0000 && !rsp_flt2)
                              ? scratch_mem_rdata0 : '0;

    // Grant FSM state and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= 2'd0;
            rr_ptr        <= 2'd0;
            beat_cnt      <= '0;
            idle_cnt      <= '0;
            timeout_fault <= 1'b0;
        end else begin
            state         <= state_nx;
            owner         <= owner_nx;
            rr_ptr        <= rr_ptr_nx;
            beat_cnt      <= beat_nx;
            idle_cnt      <= idle_nx;
            timeout_fault <= tof_nx;
        end
    end

    // Next grant: pick in IDLE, hold the lock until last, cap or watchdog.
    always_comb begin
        logic ex;
        state_nx  = state;
        owner_nx  = owner;
        rr_ptr_nx = rr_ptr;
        beat_nx   = beat_cnt;
        idle_nx   = idle_cnt;
        tof_nx    = timeout_fault;
        ex        = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nx = pick_idx;
                    state_nx = BURST;
                end
            end
            BURST: begin
                if (acc) begin
                    beat_nx = beat_cnt + 1'b1;
                    idle_nx = '0;
                    if (sel_last || beat_cnt == BC_W'(MAX_BURST - 1)) begin
                        ex = 1'b1;
                    end
                end else begin
                    idle_nx = idle_cnt + 1'b1;
                    if (idle_cnt == IC_W'(TIMEOUT - 1)) begin
                        ex     = 1'b1;
                        tof_nx = 1'b1;
                    end
                end
                if (ex) begin
                    state_nx  = IDLE;
                    rr_ptr_nx = (owner == 2'(NUM_REQ - 1)) ? 2'd0
                                                           : owner + 2'd1;
                    beat_nx   = '0;
                    idle_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Beat issue and the two-stage read response pipe carrying the owner.
    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_mem_WE     <= 1'b0;
            scratch_mem_waddr  <= '0;
            scratch_mem_wdata  <= '0;
            scratch_mem_raddr0 <= '0;
            rd_v1              <= 1'b0;
            rd_own1            <= 2'd0;
            rd_flt1            <= 1'b0;
            rsp_oh             <= 4'b0000;
            rsp_flt2           <= 1'b0;
            overflow_fault     <= 1'b0;
        end else begin
            scratch_mem_WE <= acc && sel_we && !flt;
            if (acc && sel_we && !flt) begin
                scratch_mem_waddr <= sel_addr;
                scratch_mem_wdata <= sel_wdata;
            end
            if (acc && !sel_we && !flt) begin
                scratch_mem_raddr0 <= sel_addr;
            end
            rd_v1    <= acc && !sel_we;
            rd_own1  <= owner;
            rd_flt1  <= flt;
            rsp_oh   <= rd_v1 ? (4'b0001 << rd_own1) : 4'b0000;
            rsp_flt2 <= rd_flt1;
            if (acc && flt) begin
                overflow_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Bench for scratch_mem_arbiter: per-requester beat drivers,
// a write/read scoreboard, a vector table and burst/reset sequences.
module tb_scratch_mem_arbiter;

    typedef struct {
        logic         we;
        logic         last;
        logic [15:0]  addr;
        logic [127:0] data;
    } beat_t;

    typedef struct {
        int           due;
        logic [2:0]   id_oh;
        logic [15:0]  addr;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        int          id;
        logic        we;
        logic [15:0] addr;
        logic [16:0] depth;
        logic        ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [16:0]  depth = 17'h10000;
    logic         mem_we;
    logic [15:0]  waddr;
    logic [127:0] wdata;
    logic [15:0]  raddr0;
    logic [127:0] rdata0 = '0;
    logic [1:0]   owner;
    logic         ovf;
    logic         tof;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    beat_t drv [3][$];
    exp_t  wq[$];
    exp_t  rq[$];
    int    g_own[$];
    int    g_len[$];
    int    we_cyc[$];
    int    rsp_cyc[$];
    int    gstart = 0;
    logic [2:0] acc_q = '0;
    logic [2:0] prev_rdy = '0;

    vec_t tbl[9];
    int   t1_we[6] = '{3, 4, 6, 7, 9, 10};
    int   t1_own[3] = '{0, 1, 2};
    int   t3_own[4] = '{0, 1, 0, 2};
    int   t3_len[4] = '{16, 1, 68, 1};

    scratch_mem_arbiter_if #(
        .NUM_REQ(3), .ADDR_W(16), .DATA_W(128)
    ) bus ();

    scratch_mem_arbiter dut (
        .clock             (clk),
        .reset             (reset),
        .req_if            (bus),
        .scratch_mem_depth (depth),
        .scratch_mem_WE    (mem_we),
        .scratch_mem_waddr (waddr),
        .scratch_mem_wdata (wdata),
        .scratch_mem_raddr0(raddr0),
        .scratch_mem_rdata0(rdata0),
        .owner             (owner),
        .overflow_fault    (ovf),
        .timeout_fault     (tof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] mem_word(input logic [15:0] a);
        return {8{a}};
    endfunction

    always @(posedge clk) rdata0 <= mem_word(raddr0);

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Requester drivers: present queue heads, pop on handshake.
    initial begin
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_last  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (acc_q[i] && drv[i].size() > 0) begin
                    void'(drv[i].pop_front());
                end
                if (drv[i].size() > 0) begin
                    bus.req_valid[i]            = 1'b1;
                    bus.req_we[i]               = drv[i][0].we;
                    bus.req_last[i]             = drv[i][0].last;
                    bus.req_addr[i*16 +: 16]    = drv[i][0].addr;
                    bus.req_wdata[i*128 +: 128] = drv[i][0].data;
                end else begin
                    bus.req_valid[i]            = 1'b0;
                    bus.req_we[i]               = 1'b0;
                    bus.req_last[i]             = 1'b0;
                    bus.req_addr[i*16 +: 16]    = '0;
                    bus.req_wdata[i*128 +: 128] = '0;
                end
            end
        end
    end

    // Monitor and scoreboard.
    always @(negedge clk) begin
        exp_t e;
        int   oi;
        logic flt;
        if (reset) begin
            acc_q    = '0;
            prev_rdy = '0;
        end else begin
            if (mem_we || (wq.size() > 0 && wq[0].due <= cyc)) begin
                if (wq.size() == 0) begin
                    chki("we_unexpected", int'(mem_we), 0);
                end else begin
                    e = wq.pop_front();
                    chki("we_cycle", cyc, e.due);
                    chki("we_flag", int'(mem_we), 1);
                    chk("waddr", 128'(waddr), 128'(e.addr));
                    chk("wdata", wdata, e.data);
                end
                if (mem_we) we_cyc.push_back(cyc);
            end
            if (bus.rsp_valid != 0 ||
                (rq.size() > 0 && rq[0].due <= cyc)) begin
                if (rq.size() == 0) begin
                    chk("rsp_unexpected", 128'(bus.rsp_valid), 128'(0));
                end else begin
                    e = rq.pop_front();
                    chki("rsp_cycle", cyc, e.due);
                    chk("rsp_valid", 128'(bus.rsp_valid), 128'(e.id_oh));
                    chk("rsp_rdata", bus.rsp_rdata, e.data);
                end
                if (bus.rsp_valid != 0) rsp_cyc.push_back(cyc);
            end
            oi = 0;
            for (int i = 0; i < 3; i++) begin
                if (bus.req_ready[i]) oi = i;
            end
            if (bus.req_ready != 0 && prev_rdy == 0) begin
                g_own.push_back(oi);
                gstart = cyc;
                chki("owner_port", int'(owner), oi);
            end
            if (bus.req_ready == 0 && prev_rdy != 0) begin
                g_len.push_back(cyc - gstart);
            end
            prev_rdy = bus.req_ready;
            acc_q = bus.req_valid & bus.req_ready;
            for (int i = 0; i < 3; i++) begin
                if (acc_q[i] && drv[i].size() > 0) begin
                    flt = {1'b0, drv[i][0].addr} >= depth;
                    e.addr  = drv[i][0].addr;
                    e.id_oh = 3'b001 << i;
                    if (drv[i][0].we) begin
                        e.due  = cyc + 1;
                        e.data = drv[i][0].data;
                        if (!flt) wq.push_back(e);
                    end else begin
                        e.due  = cyc + 2;
                        e.data = flt ? '0 : mem_word(drv[i][0].addr);
                        rq.push_back(e);
                    end
                end
            end
        end
    end

    task automatic push_beat(input int id, input logic we,
                             input logic last, input logic [15:0] addr);
        beat_t b;
        b.we   = we;
        b.last = last;
        b.addr = addr;
        b.data = {$urandom, $urandom, $urandom, $urandom};
        drv[id].push_back(b);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (n < bound &&
               !(drv[0].size() == 0 && drv[1].size() == 0 &&
                 drv[2].size() == 0 && wq.size() == 0 &&
                 rq.size() == 0 && bus.req_ready == 0)) begin
            @(negedge clk);
            n++;
        end
        chki("drain_in_time", int'(n < bound), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_logs();
        g_own.delete();
        g_len.delete();
        we_cyc.delete();
        rsp_cyc.delete();
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_ready"}, 128'(bus.req_ready), 128'(0));
        chk({p, "_rsp_valid"}, 128'(bus.rsp_valid), 128'(0));
        chk({p, "_rsp_rdata"}, bus.rsp_rdata, 128'(0));
        chk({p, "_we"}, 128'(mem_we), 128'(0));
        chk({p, "_waddr"}, 128'(waddr), 128'(0));
        chk({p, "_wdata"}, wdata, 128'(0));
        chk({p, "_raddr0"}, 128'(raddr0), 128'(0));
        chk({p, "_owner"}, 128'(owner), 128'(0));
        chk({p, "_ovf"}, 128'(ovf), 128'(0));
        chk({p, "_tof"}, 128'(tof), 128'(0));
    endtask

    initial begin
        int c;
        int n;
        tbl[0] = '{0, 1'b1, 16'h0005, 17'h00100, 1'b0};
        tbl[1] = '{1, 1'b0, 16'h0005, 17'h00100, 1'b0};
        tbl[2] = '{2, 1'b1, 16'h00FF, 17'h00100, 1'b0};
        tbl[3] = '{2, 1'b0, 16'h00FF, 17'h00100, 1'b0};
        tbl[4] = '{0, 1'b1, 16'hFFFF, 17'h10000, 1'b0};
        tbl[5] = '{1, 1'b0, 16'hFFFF, 17'h10000, 1'b0};
        tbl[6] = '{1, 1'b1, 16'h0100, 17'h00100, 1'b1};
        tbl[7] = '{0, 1'b0, 16'h0100, 17'h00100, 1'b1};
        tbl[8] = '{2, 1'b1, 16'h0000, 17'h00000, 1'b1};

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        clear_logs();
        c = cyc;
        for (int i = 0; i < 3; i++) begin
            push_beat(i, 1'b1, 1'b0, 16'(16'h0040 + 2 * i));
            push_beat(i, 1'b1, 1'b1, 16'(16'h0041 + 2 * i));
        end
        wait_drain(60);
        chki("t1_grant_n", g_own.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chki("t1_grant", k < g_own.size() ? g_own[k] : -1, t1_own[k]);
        end
        chki("t1_we_n", we_cyc.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chki("t1_we_at", k < we_cyc.size() ? we_cyc[k] - c : -1,
                 t1_we[k]);
        end

        clear_logs();
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            push_beat(1, 1'b0, k == 3, 16'(16'h0010 + k));
        end
        wait_drain(60);
        chki("t2_rsp_n", rsp_cyc.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chki("t2_rsp_at", k < rsp_cyc.size() ? rsp_cyc[k] - c : -1,
                 4 + k);
        end
        chki("t2_len", g_len.size() > 0 ? g_len[0] : -1, 4);

        for (int k = 0; k < 9; k++) begin
            clear_logs();
            depth = tbl[k].depth;
            push_beat(tbl[k].id, tbl[k].we, 1'b1, tbl[k].addr);
            wait_drain(60);
            chki("tbl_owner", int'(owner), tbl[k].id);
            chki("tbl_grant", g_own.size() > 0 ? g_own[0] : -1, tbl[k].id);
            chki("tbl_ovf", int'(ovf), int'(tbl[k].ovf));
        end
        depth = 17'h10000;

        clear_logs();
        for (int k = 0; k < 20; k++) begin
            push_beat(0, 1'b1, 1'b0, 16'(16'h0200 + k));
        end
        repeat (3) @(negedge clk);
        push_beat(1, 1'b1, 1'b1, 16'h0300);
        repeat (27) @(negedge clk);
        chki("t3_tof_pre", int'(tof), 0);
        push_beat(2, 1'b0, 1'b1, 16'h0301);
        wait_drain(400);
        chki("t3_tof_post", int'(tof), 1);
        chki("t3_grant_n", g_own.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chki("t3_grant", k < g_own.size() ? g_own[k] : -1, t3_own[k]);
            chki("t3_len", k < g_len.size() ? g_len[k] : -1, t3_len[k]);
        end
        chki("t3_we_n", we_cyc.size(), 21);

        clear_logs();
        for (int k = 0; k < 8; k++) begin
            push_beat(2, k % 2 == 0, 1'b0, 16'(16'h0020 + k / 2));
        end
        n = 0;
        while (drv[2].size() > 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chki("rst_reached", int'(n < 100), 1);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) drv[i].delete();
        wq.delete();
        rq.delete();
        @(negedge clk);
        check_reset_vals("mid");
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chki("rst_no_stale", wq.size() + rq.size(), 0);
        push_beat(1, 1'b1, 1'b1, 16'h0033);
        wait_drain(60);
        chki("post_rst_owner", int'(owner), 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
